prach_hb_dec: RTL and testbench

//  Parametrised half-band decimate-by-2 stage for the PRACH long-sequence chain. Successor to the fixed 2-path hb2.

---
 rtl/prach_pkg.sv | 30 +++
 rtl/prach_hb_dec_if.sv | 27 ++
 rtl/prach_hb_dec_path.sv | 115 +++++++++++
 rtl/prach_hb_dec.sv | 86 ++++++++
 tb/tb_prach_hb_dec.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH decimator chain: coefficient type, stage latency,
// and rounding/saturation helpers evaluated on a wide signed intermediate.
package prach_pkg;

    localparam int unsigned HB_LAT    = 6;
    localparam int unsigned HB_COEF_W = 18;

    typedef logic signed [HB_COEF_W-1:0] hb_coef_t;

    // Q17 half-band taps, outer pair first; 2*sum + 0.5 gives unity DC gain
    localparam hb_coef_t HB_COEF_DEF [3] = '{18'sd1536, -18'sd8192, 18'sd39424};

    // Round half-up: add half an output LSB, then drop sh fractional bits
    function automatic logic signed [63:0] round_hu(input logic signed [63:0] v,
                                                    input int unsigned      sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/prach_hb_dec_if.sv
// Sample/control bundle of the half-band decimator: polyphase input beat and decimated output beat.
interface prach_hb_dec_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_PATHS = 2,
    parameter int unsigned CHN_W     = 8
);
    logic                                     bypass;
    logic signed [NUM_PATHS-1:0][DATA_W-1:0]  din_dp1;
    logic signed [NUM_PATHS-1:0][DATA_W-1:0]  din_dp2;
    logic                                     din_dv;
    logic        [CHN_W-1:0]                  din_chn;
    logic                                     sync_in;
    logic signed [NUM_PATHS-1:0][DATA_W-1:0]  dout_dq;
    logic                                     dout_dv;
    logic        [CHN_W-1:0]                  dout_chn;
    logic                                     sync_out;

    modport master (
        output bypass, din_dp1, din_dp2, din_dv, din_chn, sync_in,
        input  dout_dq, dout_dv, dout_chn, sync_out
    );

    modport slave (
        input  bypass, din_dp1, din_dp2, din_dv, din_chn, sync_in,
        output dout_dq, dout_dv, dout_chn, sync_out
    );
endinterface

// File: rtl/prach_hb_dec_path.sv
// One datapath of the half-band decimator: per-channel history, pre-add, MAC,
// round/saturate and bypass mux, six register stages from input to dq.
module prach_hb_dec_path import prach_pkg::*; #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 18,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned NTAP   = 3,
    parameter logic signed [COEF_W-1:0] COEF [NTAP] = HB_COEF_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     flush,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [DATA_W-1:0] dp1,
    input  logic signed [DATA_W-1:0] dp2,
    input  logic                     ok,
    input  logic                     byp,
    output logic signed [DATA_W-1:0] dq
);

    localparam int unsigned HL     = 2 * NTAP;
    localparam int unsigned DL     = NTAP - 1;
    localparam int unsigned PRE_W  = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NTAP) + 1;

    logic signed [DATA_W-1:0] hist     [NUM_CH][HL];
    logic signed [DATA_W-1:0] dly      [NUM_CH][DL];
    logic signed [DATA_W-1:0] old_line [HL];
    logic signed [DATA_W-1:0] new_line [HL];
    logic signed [DATA_W-1:0] old_dl   [DL];
    logic signed [DATA_W-1:0] new_dl   [DL];
    logic signed [DATA_W-1:0] d_tap;

    logic signed [DATA_W-1:0] s1_line [HL];
    logic signed [DATA_W-1:0] s1_d, s2_d;
    logic signed [PRE_W-1:0]  s2_pre  [NTAP];
    logic signed [PROD_W-1:0] s3_prod [NTAP];
    logic signed [ACC_W-1:0]  s3_ctr, s4_acc, acc_c;
    logic signed [DATA_W-1:0] s5_y;
    logic signed [DATA_W-1:0] raw [5];

    // A sync beat sees an all-zero line, so it enters a clean history
    always_comb begin
        old_line = '{default: '0};
        old_dl   = '{default: '0};
        if (!flush) begin
            old_line = hist[idx];
            old_dl   = dly[idx];
        end
        new_line[0] = dp1;
        for (int i = 1; i < HL; i++) new_line[i] = old_line[i-1];
        new_dl[0] = dp2;
        for (int i = 1; i < DL; i++) new_dl[i] = old_dl[i-1];
        d_tap = old_dl[DL-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < HL; i++) hist[c][i] <= '0;
                for (int i = 0; i < DL; i++) dly[c][i]  <= '0;
            end
        end else begin
            if (flush) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int i = 0; i < HL; i++) hist[c][i] <= '0;
                    for (int i = 0; i < DL; i++) dly[c][i]  <= '0;
                end
            end
            if (wr) begin
                hist[idx] <= new_line;
                dly[idx]  <= new_dl;
            end
        end
    end

    always_comb begin
        acc_c = s3_ctr;
        for (int k = 0; k < NTAP; k++) acc_c = acc_c + ACC_W'(s3_prod[k]);
    end

    // Centre tap of 0.5 is a shift by COEF_W-2 in the Q(COEF_W-1) product domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_line <= '{default: '0};
            s2_pre  <= '{default: '0};
            s3_prod <= '{default: '0};
            raw     <= '{default: '0};
            s1_d    <= '0;
            s2_d    <= '0;
            s3_ctr  <= '0;
            s4_acc  <= '0;
            s5_y    <= '0;
            dq      <= '0;
        end else begin
            s1_line <= new_line;
            s1_d    <= d_tap;
            for (int k = 0; k < NTAP; k++)
                s2_pre[k] <= PRE_W'(s1_line[k]) + PRE_W'(s1_line[HL-1-k]);
            s2_d <= s1_d;
            for (int k = 0; k < NTAP; k++)
                s3_prod[k] <= PROD_W'(s2_pre[k]) * PROD_W'(COEF[k]);
            s3_ctr <= ACC_W'(s2_d) <<< (COEF_W - 2);
            s4_acc <= acc_c;
            s5_y   <= DATA_W'(sat_s(round_hu(64'(s4_acc), COEF_W - 1), DATA_W));
            raw[0] <= dp1;
            for (int i = 1; i < 5; i++) raw[i] <= raw[i-1];
            dq <= !ok ? '0 : (byp ? raw[4] : s5_y);
        end
    end

endmodule

// File: rtl/prach_hb_dec.sv
// Half-band decimate-by-2 stage for the PRACH long-sequence chain: TDM channels,
// NUM_PATHS parallel datapaths, run-time bypass and sync-driven history flush.
module prach_hb_dec import prach_pkg::*; #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned NUM_PATHS = 2,
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned CHN_W     = 8,
    parameter int unsigned NTAP      = 3,
    parameter logic signed [COEF_W-1:0] COEF [NTAP] = HB_COEF_DEF
) (
    input logic           clk,
    input logic           rst,
    prach_hb_dec_if.slave bus
);

    localparam int unsigned LAT   = HB_LAT;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             in_rng, beat_sync, wr, byp_eff, bypass_q;
    logic [IDX_W-1:0] idx;
    logic [LAT-1:0]   dv_p, sync_p;
    logic [LAT-2:0]   ok_p, byp_p;
    logic [CHN_W-1:0] chn_p [LAT];
    logic signed [DATA_W-1:0] dq_p [NUM_PATHS];

    // The sync beat itself already runs in the newly latched mode
    always_comb begin
        in_rng    = ({1'b0, bus.din_chn} < (CHN_W + 1)'(NUM_CH));
        beat_sync = bus.din_dv & bus.sync_in;
        wr        = bus.din_dv & in_rng;
        idx       = in_rng ? IDX_W'(bus.din_chn) : '0;
        byp_eff   = beat_sync ? bus.bypass : bypass_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_p     <= '0;
            sync_p   <= '0;
            ok_p     <= '0;
            byp_p    <= '0;
            chn_p    <= '{default: '0};
            bypass_q <= 1'b0;
        end else begin
            dv_p     <= {dv_p[LAT-2:0], bus.din_dv};
            sync_p   <= {sync_p[LAT-2:0], beat_sync};
            ok_p     <= {ok_p[LAT-3:0], wr};
            byp_p    <= {byp_p[LAT-3:0], byp_eff};
            chn_p[0] <= bus.din_dv ? bus.din_chn : '0;
            for (int i = 1; i < LAT; i++) chn_p[i] <= chn_p[i-1];
            if (beat_sync) bypass_q <= bus.bypass;
        end
    end

    for (genvar p = 0; p < NUM_PATHS; p++) begin : g_path
        prach_hb_dec_path #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .NUM_CH (NUM_CH),
            .IDX_W  (IDX_W),
            .NTAP   (NTAP),
            .COEF   (COEF)
        ) u_path (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr),
            .flush (beat_sync),
            .idx   (idx),
            .dp1   (bus.din_dp1[p]),
            .dp2   (bus.din_dp2[p]),
            .ok    (ok_p[LAT-2]),
            .byp   (byp_p[LAT-2]),
            .dq    (dq_p[p])
        );
    end

    always_comb begin
        bus.dout_dq = '0;
        for (int p = 0; p < NUM_PATHS; p++) bus.dout_dq[p] = dq_p[p];
    end

    assign bus.dout_dv  = dv_p[LAT-1];
    assign bus.sync_out = sync_p[LAT-1];
    assign bus.dout_chn = chn_p[LAT-1];

endmodule

// File: tb/tb_prach_hb_dec.sv
// Directed bench for prach_hb_dec: impulse, saturation, TDM isolation, flush, bypass, mid-stream reset.
module tb_prach_hb_dec;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prach_hb_dec_if #(.DATA_W(16), .NUM_PATHS(2), .CHN_W(8)) bus ();

    prach_hb_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic               dv;
        logic [7:0]         chn;
        logic               sy;
        logic signed [15:0] q0;
        logic signed [15:0] q1;
    } exp_t;

    exp_t pipe [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stepno  = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " dv"},   32'(bus.dout_dv),  0);
        check({tag, " chn"},  32'(bus.dout_chn), 0);
        check({tag, " sync"}, 32'(bus.sync_out), 0);
        check({tag, " q0"},   $signed(bus.dout_dq[0]), 0);
        check({tag, " q1"},   $signed(bus.dout_dq[1]), 0);
    endtask

    // One input beat per call; its expectation is checked six beats later
    task automatic step(input logic dv, input int chn, input logic sy, input logic by,
                        input int a0, input int b0, input int a1, input int b1,
                        input int e0, input int e1);
        exp_t e;
        bus.din_dv     = dv;
        bus.din_chn    = 8'(chn);
        bus.sync_in    = sy;
        bus.bypass     = by;
        bus.din_dp1[0] = 16'(a0);
        bus.din_dp2[0] = 16'(b0);
        bus.din_dp1[1] = 16'(a1);
        bus.din_dp2[1] = 16'(b1);
        @(posedge clk);
        #1;
        e.dv  = dv;
        e.chn = 8'(chn);
        e.sy  = dv & sy;
        e.q0  = 16'(e0);
        e.q1  = 16'(e1);
        pipe.push_back(e);
        if (pipe.size() == 6) begin
            e = pipe.pop_front();
            check($sformatf("dv@%0d", stepno), 32'(bus.dout_dv), 32'(e.dv));
            if (e.dv) begin
                check($sformatf("chn@%0d", stepno), 32'(bus.dout_chn), 32'(e.chn));
                check($sformatf("sync@%0d", stepno), 32'(bus.sync_out), 32'(e.sy));
                check($sformatf("q0@%0d", stepno), $signed(bus.dout_dq[0]), 32'(e.q0));
                check($sformatf("q1@%0d", stepno), $signed(bus.dout_dq[1]), 32'(e.q1));
            end
        end else begin
            check($sformatf("early dv@%0d", stepno), 32'(bus.dout_dv), 0);
        end
        stepno++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    localparam int P = 32767;
    localparam int N = -32768;

    initial begin
        bus.din_dv  = 1'b0;
        bus.din_chn = '0;
        bus.sync_in = 1'b0;
        bus.bypass  = 1'b0;
        bus.din_dp1 = '0;
        bus.din_dp2 = '0;
        #1;
        check_idle("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_idle("reset held");
        rst = 1'b0;

        // Impulse on dp1, then dp2 impulse and half-LSB rounding on path 1
        step(1, 0, 0, 0, 16384, 0, -16384, 0,   192,  -192);
        step(1, 0, 0, 0, 0, 0, 0, 0,          -1024,  1024);
        step(1, 0, 0, 0, 0, 0, 0, 0,           4928, -4928);
        step(1, 0, 0, 0, 0, 0, 0, 0,           4928, -4928);
        step(1, 0, 0, 0, 0, 0, 0, 0,          -1024,  1024);
        step(1, 0, 0, 0, 0, 0, 0, 0,            192,  -192);
        step(1, 0, 0, 0, 0, 0, 0, 0,              0,     0);
        step(1, 0, 0, 0, 0, 16384, 0, 3,          0,     0);
        step(1, 0, 0, 0, 0, 0, 0, -3,             0,     0);
        step(1, 0, 0, 0, 0, 0, 0, 0,           8192,     2);
        step(1, 0, 0, 0, 0, 0, 0, 0,              0,    -1);
        step(1, 0, 0, 0, 0, 0, 0, 0,              0,     0);

        // Full-scale step on channel 1: overshoot must clip, not wrap
        step(1, 1, 0, 0, P, P, N, N,   384,   -384);
        step(1, 1, 0, 0, P, P, N, N, -1664,   1664);
        step(1, 1, 0, 0, P, P, N, N, 24575, -24576);
        step(1, 1, 0, 0, P, P, N, N,     P,      N);
        step(1, 1, 0, 0, P, P, N, N, 32383, -32384);
        step(1, 1, 0, 0, P, P, N, N,     P,      N);
        step(1, 1, 0, 0, P, P, N, N,     P,      N);

        // Impulse on chn 3 interleaved with full-scale chn 1 and an out-of-range tag
        step(1, 3, 0, 0, 16384, 0, -16384, 0,   192,  -192);
        step(1, 1, 0, 0, P, P, N, N,              P,     N);
        step(1, 3, 0, 0, 0, 0, 0, 0,          -1024,  1024);
        step(1, 9, 0, 0, 5000, 5000, 5000, 5000,  0,     0);
        step(0, 0, 0, 0, 0, 0, 0, 0,              0,     0);
        step(1, 1, 0, 0, P, P, N, N,              P,     N);
        step(1, 3, 0, 0, 0, 0, 0, 0,           4928, -4928);
        step(1, 3, 0, 0, 0, 0, 0, 0,           4928, -4928);
        step(1, 1, 0, 0, P, P, N, N,              P,     N);
        step(1, 3, 0, 0, 0, 0, 0, 0,          -1024,  1024);
        step(1, 3, 0, 0, 0, 0, 0, 0,            192,  -192);

        // Sync without dv is ignored; sync beat then flushes every channel
        step(0, 0, 1, 1, 0, 0, 0, 0,              0,     0);
        step(1, 1, 0, 0, 0, 0, 0, 0,          32383, -32384);
        step(1, 0, 1, 0, 0, 0, 0, 0,              0,     0);
        step(1, 1, 0, 0, 0, 0, 0, 0,              0,     0);
        step(1, 3, 0, 0, 0, 0, 0, 0,              0,     0);

        // Bypass latched on sync only; out-of-range still gives zero
        step(1, 2, 1, 1, 1234, 5, -777, 5,     1234,  -777);
        step(1, 2, 0, 0, -20000, 0, 31000, 0, -20000, 31000);
        step(1, 5, 0, 0, 7, 0, 7, 0,              7,     7);
        step(1, 200, 0, 1, 99, 0, 99, 0,          0,     0);
        step(1, 2, 1, 0, 16384, 0, 0, 0,        192,     0);
        idle(6);

        // Reset in the middle of a stream of beats
        step(1, 0, 0, 0, 11111, 11111, 11111, 11111, 0, 0);
        step(1, 0, 0, 0, 11111, 11111, 11111, 11111, 0, 0);
        step(1, 0, 0, 0, 11111, 11111, 11111, 11111, 0, 0);
        rst = 1'b1;
        #1;
        check_idle("mid reset");
        @(posedge clk);
        #1;
        check_idle("mid reset c1");
        @(posedge clk);
        #1;
        check_idle("mid reset c2");
        rst = 1'b0;
        pipe.delete();
        step(1, 0, 0, 0, 16384, 0, 16384, 0,   192,   192);
        step(1, 0, 0, 0, 0, 0, 0, 0,         -1024, -1024);
        step(1, 0, 0, 0, 0, 0, 0, 0,          4928,  4928);
        step(1, 0, 0, 0, 0, 0, 0, 0,          4928,  4928);
        step(1, 0, 0, 0, 0, 0, 0, 0,         -1024, -1024);
        step(1, 0, 0, 0, 0, 0, 0, 0,           192,   192);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
